// File: rtl/main_mem_arb_pkg.sv
// Shared types for the main-memory data-port arbiter.
//   MEM_A_WIDTH : word-address width of the main memory
//   port_t      : requester index (0 = CPU load/store, 1 = DMA/blitter)
//   mem_cmd_t   : one accepted memory command as held in the command stage
package main_mem_arb_pkg;

    localparam int MEM_A_WIDTH = 13;

    typedef logic port_t;

    localparam port_t PORT_CPU = 1'b0;
    localparam port_t PORT_DMA = 1'b1;

    typedef struct packed {
        logic [MEM_A_WIDTH-1:0] addr;
        logic                   we;
        logic [1:0]             mask;
        logic [15:0]            wdata;
        port_t                  port;
    } mem_cmd_t;

endpackage

// File: rtl/main_mem_arbiter.sv
// Arbitrates the main-memory data port between the CPU load/store unit
// (port 0, fixed priority) and the DMA/blitter engine (port 1, starvation
// bounded by MAX_WAIT). Accepted commands are registered, driven to the
// memory one cycle later, and read data is steered back with a valid strobe.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req/addr/we/mask/wdata 0 port 0 request and fields
//   req/addr/we/mask/wdata 1 port 1 request and fields
//   gnt0, gnt1               combinational grant, same cycle as request
//   rvalid0/1, rdata0/1      read return, two cycles after the grant
//   mem_data_*               memory data port (command stage outputs)
//   mem_data_read            registered read data from the memory
module main_mem_arbiter
    import main_mem_arb_pkg::*;
#(
    parameter int A_WIDTH  = 13,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req0,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic               we0,
    input  logic [1:0]         mask0,
    input  logic [15:0]        wdata0,

    input  logic               req1,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic               we1,
    input  logic [1:0]         mask1,
    input  logic [15:0]        wdata1,

    output logic               gnt0,
    output logic               gnt1,

    output logic               rvalid0,
    output logic [15:0]        rdata0,
    output logic               rvalid1,
    output logic [15:0]        rdata1,

    output logic [A_WIDTH-1:0] mem_data_addr,
    output logic               mem_data_write_en,
    output logic [1:0]         mem_data_write_mask,
    output logic [15:0]        mem_data_write,
    input  logic [15:0]        mem_data_read
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    function automatic mem_cmd_t make_cmd(input logic [A_WIDTH-1:0] addr,
                                          input logic               we,
                                          input logic [1:0]         mask,
                                          input logic [15:0]        wdata,
                                          input port_t              port);
        mem_cmd_t c;
        c.addr  = MEM_A_WIDTH'(addr);
        c.we    = we;
        c.mask  = mask;
        c.wdata = wdata;
        c.port  = port;
        return c;
    endfunction

    logic [CW-1:0] wait_cnt;
    logic          pick0;
    logic          pick1;

    mem_cmd_t      cmd_p1;
    logic          vld_p1;

    logic          rd_vld_p2;
    port_t         rd_port_p2;

    // Arbitration: a starved port 1 overrides port 0's fixed priority.
    always_comb begin
        pick0 = 1'b0;
        pick1 = 1'b0;
        if (req1 && (wait_cnt == WAIT_LIMIT)) begin
            pick1 = 1'b1;
        end else if (req0) begin
            pick0 = 1'b1;
        end else if (req1) begin
            pick1 = 1'b1;
        end
    end

    // Grants are suppressed while reset is asserted; internal state uses the
    // raw picks because the reset branch already overrides them.
    assign gnt0 = pick0 & ~rst;
    assign gnt1 = pick1 & ~rst;

    // Consecutive losing cycles of port 1, saturating at MAX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (req1 && !pick1) begin
            if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // ---- Stage C: command register -------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cmd_p1 <= '0;
        end else begin
            vld_p1 <= pick0 | pick1;
            if (pick1) begin
                cmd_p1 <= make_cmd(addr1, we1, mask1, wdata1, PORT_DMA);
            end else if (pick0) begin
                cmd_p1 <= make_cmd(addr0, we0, mask0, wdata0, PORT_CPU);
            end
        end
    end

    // Fields stay at the last command while idle; only write_en is qualified.
    assign mem_data_addr       = A_WIDTH'(cmd_p1.addr);
    assign mem_data_write_en   = vld_p1 & cmd_p1.we;
    assign mem_data_write_mask = cmd_p1.mask;
    assign mem_data_write      = cmd_p1.wdata;

    // ---- Stage R: read return ------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p2  <= 1'b0;
            rd_port_p2 <= PORT_CPU;
        end else begin
            rd_vld_p2  <= vld_p1 & ~cmd_p1.we;
            rd_port_p2 <= cmd_p1.port;
        end
    end

    assign rvalid0 = rd_vld_p2 & (rd_port_p2 == PORT_CPU);
    assign rvalid1 = rd_vld_p2 & (rd_port_p2 == PORT_DMA);
    assign rdata0  = mem_data_read;
    assign rdata1  = mem_data_read;

endmodule

// File: tb/tb_main_mem_arbiter.sv
module tb_main_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [12:0] addr0, addr1;
    logic [1:0]  mask0, mask1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [12:0] mem_data_addr;
    logic        mem_data_write_en;
    logic [1:0]  mem_data_write_mask;
    logic [15:0] mem_data_write;
    logic [15:0] mem_data_read;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          port;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [15:0] mem [0:8191];

    main_mem_arbiter #(.A_WIDTH(13), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .we0(we0), .mask0(mask0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .mask1(mask1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rdata0(rdata0), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_data_addr(mem_data_addr), .mem_data_write_en(mem_data_write_en),
        .mem_data_write_mask(mem_data_write_mask), .mem_data_write(mem_data_write),
        .mem_data_read(mem_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Main memory model: byte-masked write, registered read.
    always @(posedge clk) begin
        if (mem_data_write_en) begin
            if (mem_data_write_mask[0]) mem[mem_data_addr][7:0]  <= mem_data_write[7:0];
            if (mem_data_write_mask[1]) mem[mem_data_addr][15:8] <= mem_data_write[15:8];
        end
        mem_data_read <= mem[mem_data_addr];
    end

    // Return monitor: every rvalid must match the oldest expected read.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rvalid port %0d: rvalid absent, required at cycle %0d (now %0d)",
                         sb[0].port, sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (rvalid0 && rvalid1) begin
                checks++;
                errors++;
                $display("FAIL rvalid_exclusive: rvalid0=1 rvalid1=1, required at most one");
            end else if (rvalid0 || rvalid1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid: rvalid0=%0b rvalid1=%0b at cycle %0d, required none",
                             rvalid0, rvalid1, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if ((rvalid1 ? 1 : 0) !== mon_e.port ||
                        (rvalid1 ? rdata1 : rdata0) !== mon_e.data ||
                        cyc !== mon_e.due) begin
                        errors++;
                        $display("FAIL read_return: port %0d data %h cycle %0d, required port %0d data %h cycle %0d",
                                 rvalid1 ? 1 : 0, rvalid1 ? rdata1 : rdata0, cyc,
                                 mon_e.port, mon_e.data, mon_e.due);
                    end
                end
            end
        end
    end

    task automatic set_port(input int p, input logic r, input logic [12:0] a,
                            input logic w, input logic [1:0] m, input logic [15:0] d);
        if (p == 0) begin
            req0 = r; addr0 = a; we0 = w; mask0 = m; wdata0 = d;
        end else begin
            req1 = r; addr1 = a; we1 = w; mask1 = m; wdata1 = d;
        end
    endtask

    task automatic push_read(input int p, input logic [15:0] d);
        exp_t e;
        e.port = p;
        e.data = d;
        e.due  = cyc + 2;
        sb.push_back(e);
    endtask

    // Called just after a negedge where port p's request is already driven.
    task automatic check_gnt(input string name, input int p);
        logic g, other;
        #1;
        g     = (p == 0) ? gnt0 : gnt1;
        other = (p == 0) ? gnt1 : gnt0;
        checks++;
        if (g !== 1'b1 || other !== 1'b0) begin
            errors++;
            $display("FAIL %s: gnt%0d=%b other=%b, required 1 and 0", name, p, g, other);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d reads outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_port(0, 1'b1, 13'h0007, 1'b1, 2'b11, 16'hFFFF);
        set_port(1, 1'b1, 13'h0008, 1'b1, 2'b11, 16'hFFFF);
        repeat (3) @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: gnt0=%b gnt1=%b, required 0 0", gnt0, gnt1);
        end
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_data_write_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rvalid0=%b rvalid1=%b we=%b, required 0 0 0",
                     rvalid0, rvalid1, mem_data_write_en);
        end
        checks++;
        if (mem_data_addr !== 13'h0 || mem_data_write_mask !== 2'b00 || mem_data_write !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h mask=%b wdata=%h, required 0 0 0",
                     mem_data_addr, mem_data_write_mask, mem_data_write);
        end
        checks++;
        if (dut.wait_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_wait_cnt: %0d, required 0", dut.wait_cnt);
        end
        set_port(0, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        mem[16'h0010] = 16'hBEEF;
        @(negedge clk);
        set_port(0, 1'b1, 13'h0010, 1'b0, 2'b00, 16'h0);
        check_gnt("single_read_gnt", 0);
        push_read(0, 16'hBEEF);
        @(negedge clk);
        set_port(0, 1'b0, 13'h0010, 1'b0, 2'b00, 16'h0);
        drain("single_read");
    endtask

    task automatic test_masked_write();
        mem[16'h0005] = 16'hAAAA;
        @(negedge clk);
        set_port(1, 1'b1, 13'h0005, 1'b1, 2'b01, 16'h1234);
        check_gnt("masked_write_gnt", 1);
        @(negedge clk);
        checks++;
        if (mem_data_write_en !== 1'b1 || mem_data_addr !== 13'h0005 ||
            mem_data_write_mask !== 2'b01 || mem_data_write !== 16'h1234) begin
            errors++;
            $display("FAIL masked_write_drive: we=%b addr=%h mask=%b wdata=%h, required 1 0005 01 1234",
                     mem_data_write_en, mem_data_addr, mem_data_write_mask, mem_data_write);
        end
        set_port(1, 1'b1, 13'h0005, 1'b0, 2'b00, 16'h0);
        check_gnt("masked_read_gnt", 1);
        push_read(1, 16'hAA34);
        @(negedge clk);
        set_port(1, 1'b0, 13'h0005, 1'b0, 2'b00, 16'h0);
        drain("masked_write");
    endtask

    task automatic test_priority();
        logic g1;
        @(negedge clk);
        set_port(0, 1'b1, 13'h0010, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b1, 13'h0010, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            g1 = (i == 4 || i == 9);
            checks++;
            if (gnt0 !== ~g1 || gnt1 !== g1) begin
                errors++;
                $display("FAIL priority_slot%0d: gnt0=%b gnt1=%b, required %b %b",
                         i, gnt0, gnt1, ~g1, g1);
            end
            push_read(g1 ? 1 : 0, 16'hBEEF);
            @(negedge clk);
        end
        set_port(0, 1'b0, 13'h0010, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b0, 13'h0010, 1'b0, 2'b00, 16'h0);
        drain("priority");
    endtask

    task automatic test_back_to_back();
        mem[16'h0001] = 16'h1111;
        mem[16'h0002] = 16'h2222;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            int p;
            p = i % 2;
            set_port(p, 1'b1, (p == 0) ? 13'h0001 : 13'h0002, 1'b0, 2'b00, 16'h0);
            set_port(1 - p, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
            check_gnt("b2b_gnt", p);
            push_read(p, (p == 0) ? 16'h1111 : 16'h2222);
            @(negedge clk);
        end
        set_port(0, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        set_port(0, 1'b1, 13'h0010, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b1, 13'h0002, 1'b0, 2'b00, 16'h0);
        check_gnt("midrst_gnt", 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        set_port(0, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || mem_data_write_en !== 1'b0) begin
                errors++;
                $display("FAIL midrst_outputs%0d: rvalid0=%b rvalid1=%b we=%b, required 0 0 0",
                         i, rvalid0, rvalid1, mem_data_write_en);
            end
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || dut.wait_cnt !== 3'd0) begin
                errors++;
                $display("FAIL midrst_release: rvalid0=%b rvalid1=%b wait_cnt=%0d, required 0 0 0",
                         rvalid0, rvalid1, dut.wait_cnt);
            end
        end
    endtask

    task automatic test_zero_mask();
        mem[16'h0003] = 16'h5555;
        @(negedge clk);
        set_port(0, 1'b1, 13'h0003, 1'b1, 2'b00, 16'hFFFF);
        check_gnt("zero_mask_gnt", 0);
        @(negedge clk);
        checks++;
        if (mem_data_write_en !== 1'b1 || mem_data_write_mask !== 2'b00 || mem_data_addr !== 13'h0003) begin
            errors++;
            $display("FAIL zero_mask_drive: we=%b mask=%b addr=%h, required 1 00 0003",
                     mem_data_write_en, mem_data_write_mask, mem_data_addr);
        end
        set_port(0, 1'b1, 13'h0003, 1'b0, 2'b00, 16'h0);
        check_gnt("zero_mask_read_gnt", 0);
        push_read(0, 16'h5555);
        @(negedge clk);
        set_port(0, 1'b0, 13'h0003, 1'b0, 2'b00, 16'h0);
        drain("zero_mask");
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (mem_data_write_en !== 1'b0 || mem_data_addr !== 13'h0003) begin
                errors++;
                $display("FAIL idle_hold: we=%b addr=%h, required 0 0003",
                         mem_data_write_en, mem_data_addr);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        set_port(0, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        set_port(1, 1'b0, 13'h0, 1'b0, 2'b00, 16'h0);
        test_reset();
        test_single_read();
        test_masked_write();
        test_priority();
        test_back_to_back();
        test_reset_mid_read();
        test_zero_mask();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/main_mem_arbiter.md
# main_mem_arbiter

Shares the single data port of the CPU's main memory between two requesters: port 0 (CPU load/store unit) and port 1 (DMA/blitter engine that fills video and data buffers). The block registers the accepted command, drives the memory data port one cycle later, and steers the registered read data back to the winning requester with a valid strobe. Port 0 has fixed priority. A wait counter bounds how long port 1 can be starved. The memory instruction port is not touched.

## Interface
- A_WIDTH, 13, word-address width; must match the main memory.
- MAX_WAIT, 4, consecutive losing cycles port 1 may accumulate before it is forced to win; ≥1.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request valid, port 0 / port 1.
- addr0 / addr1  in  A_WIDTH  word address.
- we0 / we1  in  1  1 = write, 0 = read.
- mask0 / mask1  in  2  byte-write mask; bit 0 = [7:0], bit 1 = [15:8].
- wdata0 / wdata1  in  16  write data.
- gnt0 / gnt1  out  1  combinational; request accepted this cycle.
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse.
- rdata0 / rdata1  out  16  read data, meaningful only while the matching rvalid is high.
- mem_data_addr  out  A_WIDTH  to the memory data port.
- mem_data_write_en  out  1  to the memory.
- mem_data_write_mask  out  2  to the memory.
- mem_data_write  out  16  to the memory.
- mem_data_read  in  16  registered read data from the memory; valid one cycle after its address is presented.

## Operation
- **Handshake:** a requester holds req and all of its fields stable until it sees gnt high in the same cycle. A transfer completes on a cycle with req&gnt. The requester may issue a new request in the next cycle.
- **Arbitration, evaluated every cycle:**
  - If wait_cnt == MAX_WAIT and req1, port 1 wins.
  - Else if req0, port 0 wins.
  - Else if req1, port 1 wins.
  - At most one gnt is high in any cycle.
- **wait_cnt** (width $clog2(MAX_WAIT+1)):
  - Increments when req1 is high and gnt1 is low.
  - Clears when gnt1 is high or req1 is low.
  - Saturates at MAX_WAIT.
- **Stage C (command register):** on a grant, the block latches {addr, we, mask, wdata, port} and sets cmd_valid. With no grant, cmd_valid is cleared.
- **Memory drive:** the memory outputs come directly from stage C.
  - mem_data_write_en = cmd_valid & cmd_we.
  - mem_data_addr, mask and write data are the latched fields, held from the last command when idle.
  - A write with mask 00 is still granted and issued; the memory leaves its contents unchanged.
- **Stage R (return):** on every clock, rd_pending <= cmd_valid & ~cmd_we and rd_port <= cmd_port.
  - rvalidN = rd_pending & (rd_port == N).
  - rdataN = mem_data_read for both ports (unqualified).
  - Writes produce no rvalid.
- **Ordering:** memory accesses occur in grant order. A read granted right after a write to the same address returns the new data.

## Timing
- **Read latency:** grant in cycle N, memory address presented in N+1, rvalid and rdata in N+2.
- **Write latency:** grant in N, write_en high in N+1, memory updated at the end of N+1.
- **Throughput:** one access per cycle, with back-to-back grants to either port.
- **Reset values:** gnt0 = gnt1 = 0 while rst is high, as are cmd_valid, rd_pending, rvalid0, rvalid1 and mem_data_write_en. wait_cnt = 0. mem_data_addr, mem_data_write_mask and mem_data_write = 0.
- **Reset mid-operation:** in-flight commands and reads are dropped. No rvalid is issued after reset and no write is issued.
- **Simultaneous req0 and req1 with the counter saturated:** port 1 wins. Port 0 waits, with no counter of its own.
- **Idle:** no writes occur and mem_data_addr keeps its last value.

## Structure
- Package main_mem_arb_pkg holds:
  - typedef port_t (logic, 0/1).
  - typedef mem_cmd_t, a packed struct {addr, we, mask[1:0], wdata[15:0], port}. Its addr width comes from a package localparam MEM_A_WIDTH = 13.
- Single module with no sub-module; the arbitration pick is an inline always_comb.

## Test plan
- **Single read:** reset, then preload word 0x0010 with 0xBEEF. req0 reads 0x0010 → gnt0 in cycle N, rvalid0 in N+2 with rdata0 = 0xBEEF, rvalid1 stays 0.
- **Byte-masked write then read:** port 1 writes 0x1234 to 0x0005 with mask 01 over old 0xAAAA, then port 1 reads it in the next cycle → rdata1 = 0xAA34.
- **Priority:** req0 and req1 both held high with MAX_WAIT = 4 → grants in the order 0,0,0,0,1,0,0,0,0,1… Port 1 wins on the cycle where wait_cnt reaches 4, and never waits more than 4 cycles.
- **Back-to-back mixed traffic:** alternating grants to ports 0 and 1 (reads of 0x0001 and 0x0002 holding 0x1111 and 0x2222) → each rvalid pulses exactly 2 cycles after its grant, with the matching data and no cross-steering.
- **Reset mid-read:** assert rst in cycle N+1 of a read → no rvalid in N+2, mem_data_write_en stays 0, wait_cnt = 0 after release.
- **Zero-mask write:** write with mask 00 to 0x0003 holding 0x5555 → gnt issued, the following read returns 0x5555.
